// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back, stalls on mem_ready and holds for mult/div.
module mips_multicycle_ctrl #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUOp,
   output logic             muldiv_start,
   output logic             muldiv_is_div,
   output logic             HiLoWrite,
   output logic             HiLoSel,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADDR = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_RWB     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_BRANCH  = 4'd11,
      S_JUMP    = 4'd12,
      S_MULDIV  = 4'd13,
      S_MFHL    = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             first_q, first_d;
   logic             retire_c;
   logic             fn_alu_c, fn_muldiv_c, fn_mfhl_c;

   // zero only qualifies PCWriteCond inside the datapath; the FSM does not branch on it
   logic unused_zero;
   assign unused_zero = zero;

   // Classify the R-type function field
   always_comb begin
      fn_alu_c    = (funct == FN_AND) || (funct == FN_OR)  || (funct == FN_NOR) ||
                    (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
      fn_muldiv_c = (funct == FN_MULT) || (funct == FN_DIV);
      fn_mfhl_c   = (funct == FN_MFHI) || (funct == FN_MFLO);
   end

   // State, mult/div countdown, first-cycle flag and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         first_q   <= first_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and Moore output decode (FETCH strobes gated by mem_ready)
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      first_d       = 1'b0;
      retire_c      = 1'b0;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 2'b00;
      ALUOp         = 2'b00;
      muldiv_start  = 1'b0;
      muldiv_is_div = 1'b0;
      HiLoWrite     = 1'b0;
      HiLoSel       = 1'b0;
      illegal       = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               state_d = S_MEMADDR;
            end else if (opcode == OP_ADDI) begin
               state_d = S_ADDIEX;
            end else if (opcode == OP_BEQ) begin
               state_d = S_BRANCH;
            end else if (opcode == OP_J) begin
               state_d = S_JUMP;
            end else if ((opcode == OP_RTYPE) && fn_alu_c) begin
               state_d = S_EXEC;
            end else if ((opcode == OP_RTYPE) && fn_muldiv_c) begin
               state_d = S_MULDIV;
               cnt_d   = (funct == FN_DIV) ? DIV_LOAD : MULT_LOAD;
               first_d = 1'b1;
            end else if ((opcode == OP_RTYPE) && fn_mfhl_c) begin
               state_d = S_MFHL;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEMADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               retire_c = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_RWB;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            retire_c = 1'b1;
            state_d  = S_FETCH;
         end
         S_MULDIV: begin
            muldiv_is_div = (funct == FN_DIV);
            muldiv_start  = first_q;
            if (cnt_q == '0) begin
               HiLoWrite = 1'b1;
               retire_c  = 1'b1;
               state_d   = S_FETCH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_MFHL: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            HiLoSel  = (funct == FN_MFHI);
            retire_c = 1'b1;
            state_d  = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      retired_d = retire_c ? (retired_q + CNT_W'(1)) : retired_q;
   end

   assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one default instance and one
// narrow instance (CNT_W=4, MULT_CYCLES=1) for wrap and same-cycle mult.
module tb_mips_multicycle_ctrl;

   // Control-word bit positions (bench-side encoding of every 1/2-bit output)
   localparam logic [20:0] PCW     = 21'(1) << 20;
   localparam logic [20:0] PCWC    = 21'(1) << 19;
   localparam logic [20:0] IORD    = 21'(1) << 18;
   localparam logic [20:0] MRD     = 21'(1) << 17;
   localparam logic [20:0] MWR     = 21'(1) << 16;
   localparam logic [20:0] IRW     = 21'(1) << 15;
   localparam logic [20:0] M2R     = 21'(1) << 14;
   localparam logic [20:0] RDST    = 21'(1) << 13;
   localparam logic [20:0] RW      = 21'(1) << 12;
   localparam logic [20:0] ASA     = 21'(1) << 11;
   localparam logic [20:0] ASB_4   = 21'(1) << 9;
   localparam logic [20:0] ASB_IMM = 21'(2) << 9;
   localparam logic [20:0] ASB_SH  = 21'(3) << 9;
   localparam logic [20:0] PCS_OUT = 21'(1) << 7;
   localparam logic [20:0] PCS_J   = 21'(2) << 7;
   localparam logic [20:0] AOP_SUB = 21'(1) << 5;
   localparam logic [20:0] AOP_FN  = 21'(2) << 5;
   localparam logic [20:0] STRT    = 21'(1) << 4;
   localparam logic [20:0] ISDIV   = 21'(1) << 3;
   localparam logic [20:0] HLW     = 21'(1) << 2;
   localparam logic [20:0] HLS     = 21'(1) << 1;
   localparam logic [20:0] ILL     = 21'(1);

   // Expected control words per state
   localparam logic [20:0] X_IDLE  = 21'(0);
   localparam logic [20:0] X_FNR   = MRD | ASB_4;
   localparam logic [20:0] X_FRDY  = PCW | MRD | IRW | ASB_4;
   localparam logic [20:0] X_DEC   = ASB_SH;
   localparam logic [20:0] X_DILL  = ASB_SH | ILL;
   localparam logic [20:0] X_MADDR = ASA | ASB_IMM;
   localparam logic [20:0] X_MRD   = MRD | IORD;
   localparam logic [20:0] X_MWB   = RW | M2R;
   localparam logic [20:0] X_MWR   = MWR | IORD;
   localparam logic [20:0] X_EXEC  = ASA | AOP_FN;
   localparam logic [20:0] X_RWB   = RW | RDST;
   localparam logic [20:0] X_AEX   = ASA | ASB_IMM;
   localparam logic [20:0] X_AWB   = RW;
   localparam logic [20:0] X_BR    = ASA | AOP_SUB | PCWC | PCS_OUT;
   localparam logic [20:0] X_J     = PCW | PCS_J;
   localparam logic [20:0] X_MFHI  = RW | RDST | HLS;
   localparam logic [20:0] X_MFLO  = RW | RDST;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV = 6'b011010, FN_MFHI = 6'b010000, FN_MFLO = 6'b010010;

   logic clk;
   logic rst0_n, zero0, mr0;
   logic [5:0] op0, fn0;
   logic rst1_n;
   logic [5:0] op1, fn1;

   logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_asa;
   logic [1:0] a_asb, a_pcs, a_aop;
   logic a_st, a_dv, a_hlw, a_hls, a_ill;
   logic [7:0] ret0;

   logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_asa;
   logic [1:0] b_asb, b_pcs, b_aop;
   logic b_st, b_dv, b_hlw, b_hls, b_ill;
   logic [3:0] ret1;

   logic [20:0] sig0, sig1;
   assign sig0 = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_asa,
                  a_asb, a_pcs, a_aop, a_st, a_dv, a_hlw, a_hls, a_ill};
   assign sig1 = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_asa,
                  b_asb, b_pcs, b_aop, b_st, b_dv, b_hlw, b_hls, b_ill};

   int n_tests = 0;
   int n_fail  = 0;

   mips_multicycle_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst0_n), .opcode(op0), .funct(fn0), .zero(zero0), .mem_ready(mr0),
      .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
      .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegDst(a_rdst),
      .RegWrite(a_rw), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .PCSource(a_pcs), .ALUOp(a_aop),
      .muldiv_start(a_st), .muldiv_is_div(a_dv), .HiLoWrite(a_hlw), .HiLoSel(a_hls),
      .illegal(a_ill), .retired(ret0)
   );

   mips_multicycle_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(3), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst1_n), .opcode(op1), .funct(fn1), .zero(1'b0), .mem_ready(1'b1),
      .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
      .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegDst(b_rdst),
      .RegWrite(b_rw), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .PCSource(b_pcs), .ALUOp(b_aop),
      .muldiv_start(b_st), .muldiv_is_div(b_dv), .HiLoWrite(b_hlw), .HiLoSel(b_hls),
      .illegal(b_ill), .retired(ret1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Immediate value check, no time consumed
   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check one cycle's control word, then advance to the next cycle
   task automatic cyc(input bit u, input string tag, input logic [20:0] exp);
      logic [20:0] obs;
      #1;
      obs = u ? sig1 : sig0;
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0;
      zero0 = 1'b0; mr0 = 1'b1;
      op0 = OP_R; fn0 = FN_ADD; op1 = OP_R; fn1 = FN_ADD;
      repeat (2) @(posedge clk);
      #1;
      chk_val("reset_ctl", 32'(sig0), 32'(0));
      chk_val("reset_ret", 32'(ret0), 32'(0));

      // Reset release: one IDLE cycle, then the add/lw/sw/beq/j stream
      rst0_n = 1'b1;
      cyc(0, "idle", X_IDLE);
      op0 = OP_R; fn0 = FN_ADD;
      cyc(0, "add_f", X_FRDY); cyc(0, "add_d", X_DEC); cyc(0, "add_x", X_EXEC); cyc(0, "add_wb", X_RWB);
      op0 = OP_LW;
      cyc(0, "lw_f", X_FRDY); cyc(0, "lw_d", X_DEC); cyc(0, "lw_a", X_MADDR);
      cyc(0, "lw_rd", X_MRD); cyc(0, "lw_wb", X_MWB);
      op0 = OP_SW;
      cyc(0, "sw_f", X_FRDY); cyc(0, "sw_d", X_DEC); cyc(0, "sw_a", X_MADDR); cyc(0, "sw_wr", X_MWR);
      op0 = OP_BEQ;
      cyc(0, "beq_f", X_FRDY); cyc(0, "beq_d", X_DEC); cyc(0, "beq_b", X_BR);
      op0 = OP_J;
      cyc(0, "j_f", X_FRDY); cyc(0, "j_d", X_DEC); cyc(0, "j_j", X_J);
      chk_val("ret_stream", 32'(ret0), 32'(5));

      // lw with 3 stall cycles in FETCH and 2 in MEMRD: 10 cycles
      op0 = OP_LW; mr0 = 1'b0;
      cyc(0, "lws_f0", X_FNR); cyc(0, "lws_f1", X_FNR); cyc(0, "lws_f2", X_FNR);
      mr0 = 1'b1;
      cyc(0, "lws_f3", X_FRDY); cyc(0, "lws_d", X_DEC); cyc(0, "lws_a", X_MADDR);
      mr0 = 1'b0;
      cyc(0, "lws_rd0", X_MRD); cyc(0, "lws_rd1", X_MRD);
      mr0 = 1'b1;
      cyc(0, "lws_rd2", X_MRD); cyc(0, "lws_wb", X_MWB);
      chk_val("ret_lw_stall", 32'(ret0), 32'(6));

      // beq with zero high then low: same control word both times
      op0 = OP_BEQ; zero0 = 1'b1;
      cyc(0, "beq1_f", X_FRDY); cyc(0, "beq1_d", X_DEC); cyc(0, "beq1_b", X_BR);
      zero0 = 1'b0;
      cyc(0, "beq0_f", X_FRDY); cyc(0, "beq0_d", X_DEC); cyc(0, "beq0_b", X_BR);
      chk_val("ret_beq", 32'(ret0), 32'(8));

      // mult (4 cycles in MULDIV), div (32), mfhi, mflo, addi
      op0 = OP_R; fn0 = FN_MULT;
      cyc(0, "mul_f", X_FRDY); cyc(0, "mul_d", X_DEC); cyc(0, "mul_c3", STRT);
      cyc(0, "mul_c4", X_IDLE); cyc(0, "mul_c5", X_IDLE); cyc(0, "mul_c6", HLW);
      fn0 = FN_DIV;
      cyc(0, "div_f", X_FRDY); cyc(0, "div_d", X_DEC); cyc(0, "div_c3", STRT | ISDIV);
      for (int i = 0; i < 30; i++) cyc(0, "div_mid", ISDIV);
      cyc(0, "div_c34", ISDIV | HLW);
      fn0 = FN_MFHI;
      cyc(0, "mfhi_f", X_FRDY); cyc(0, "mfhi_d", X_DEC); cyc(0, "mfhi_wb", X_MFHI);
      fn0 = FN_MFLO;
      cyc(0, "mflo_f", X_FRDY); cyc(0, "mflo_d", X_DEC); cyc(0, "mflo_wb", X_MFLO);
      op0 = OP_ADDI;
      cyc(0, "addi_f", X_FRDY); cyc(0, "addi_d", X_DEC); cyc(0, "addi_x", X_AEX); cyc(0, "addi_wb", X_AWB);
      chk_val("ret_muldiv", 32'(ret0), 32'(13));

      // Illegal opcode and illegal R-type funct: pulse in DECODE, no retire
      op0 = 6'b111111;
      cyc(0, "ill_f", X_FRDY); cyc(0, "ill_d", X_DILL);
      op0 = OP_R; fn0 = 6'b000001;
      cyc(0, "illfn_f", X_FRDY); cyc(0, "illfn_d", X_DILL);
      chk_val("ret_illegal", 32'(ret0), 32'(13));
      fn0 = FN_SUB;
      cyc(0, "sub_f", X_FRDY); cyc(0, "sub_d", X_DEC); cyc(0, "sub_x", X_EXEC); cyc(0, "sub_wb", X_RWB);
      chk_val("ret_sub", 32'(ret0), 32'(14));

      // Reset in the middle of a div countdown
      fn0 = FN_DIV;
      cyc(0, "divr_f", X_FRDY); cyc(0, "divr_d", X_DEC); cyc(0, "divr_c3", STRT | ISDIV);
      for (int i = 0; i < 20; i++) cyc(0, "divr_mid", ISDIV);
      rst0_n = 1'b0;
      #1;
      chk_val("async_rst_ctl", 32'(sig0), 32'(0));
      chk_val("async_rst_ret", 32'(ret0), 32'(0));
      @(posedge clk); #1;
      chk_val("rst_hold_ctl", 32'(sig0), 32'(0));
      rst0_n = 1'b1;
      cyc(0, "rel_idle", X_IDLE);
      cyc(0, "rel_fetch", X_FRDY);

      // Narrow instance: mult with MULT_CYCLES=1, then jumps until retired wraps
      rst1_n = 1'b1;
      cyc(1, "n_idle", X_IDLE);
      op1 = OP_R; fn1 = FN_MULT;
      cyc(1, "n_mul_f", X_FRDY); cyc(1, "n_mul_d", X_DEC); cyc(1, "n_mul_c3", STRT | HLW);
      chk_val("n_ret_mul", 32'(ret1), 32'(1));
      op1 = OP_J;
      for (int i = 0; i < 15; i++) begin
         cyc(1, "n_j_f", X_FRDY); cyc(1, "n_j_d", X_DEC); cyc(1, "n_j_j", X_J);
      end
      chk_val("n_ret_wrap0", 32'(ret1), 32'(0));
      cyc(1, "n_j_f", X_FRDY); cyc(1, "n_j_d", X_DEC); cyc(1, "n_j_j", X_J);
      chk_val("n_ret_wrap1", 32'(ret1), 32'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
